press_count_display: RTL and testbench

- Consumes the single-cycle press pulse from buttonpressdetector.
- Keeps a DIGITS-wide BCD count of presses and drives a time-multiplexed common-anode 7-segment display.
- Downstream stage of the debounced-counter datapath; the bench responder taps its count and overflow outputs.

---
 rtl/press_count_pkg.sv | 30 +++
 rtl/press_count_display_bcd_decade.sv | 43 ++++
 rtl/press_count_display.sv | 112 +++++++++++
 tb/tb_press_count_display.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/press_count_pkg.sv
// Shared types, the blank-segment constant and the BCD to 7-segment encoder
// for the press counter display.
package press_count_pkg;

  typedef logic [3:0] bcd_t;

  // All segments off on a common-anode display (active-low drive).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
  // Codes A-F cannot occur in a valid count, so they show nothing.
  function automatic logic [6:0] bcd_to_seg(input bcd_t d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/press_count_display_bcd_decade.sv
// One decimal decade of the press counter. It advances only when the global
// increment is present and every lower decade is at 9 (carry_in), and
// reports carry_out when it is itself at 9 with carry_in set.
module bcd_decade
  import press_count_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  input  logic carry_in,
  output bcd_t value,
  output logic carry_out
);

  bcd_t value_q;
  bcd_t value_d;
  logic at_nine;

  // Next decade value: clear dominates, otherwise count 0..9 on a carried increment.
  always_comb begin
    at_nine = (value_q == 4'd9);
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc && carry_in) begin
      value_d = at_nine ? 4'd0 : value_q + 4'd1;
    end
  end

  // Decade register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value     = value_q;
  assign carry_out = carry_in & at_nine;

endmodule

// File: rtl/press_count_display.sv
// Press counter with a multiplexed common-anode 7-segment readout.
// A chain of BCD decades holds the count; a prescaler paces a scan index
// that selects which digit the registered seg/digit_en outputs show.
module press_count_display
  import press_count_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pressPulse,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  overflow,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  // carry[i] is high when decades below i are all 9; carry[DIGITS] means all-9s.
  logic [DIGITS:0] carry;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_decade
    bcd_decade u_decade (
      .clock     (clock),
      .reset     (reset),
      .inc       (pressPulse),
      .clr       (clear),
      .carry_in  (carry[i]),
      .value     (count_bcd[4*i +: 4]),
      .carry_out (carry[i+1])
    );
  end

  logic overflow_q, overflow_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic tick;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [6:0] seg_q, seg_d;
  logic [DIGITS-1:0] digit_en_q, digit_en_d;
  bcd_t sel_digit;
  logic nz_above;
  logic blank_sel;

  // Wrap pulse: an accepted press while every decade reads 9.
  always_comb begin
    overflow_d = pressPulse & ~clear & carry[DIGITS];
  end

  // Prescaler: free-running 0..SCAN_DIV-1, tick on the last count.
  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  // Scan FSM next state: step through digits on each tick, wrapping after the last.
  always_comb begin
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Scan FSM outputs: pick the digit entering the slot and decide leading-zero blanking.
  always_comb begin
    sel_digit = '0;
    nz_above  = 1'b0;
    blank_sel = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nz_above = nz_above | (count_bcd[4*k +: 4] != 4'd0);
      if (IDX_W'(k) == idx_d) begin
        sel_digit = count_bcd[4*k +: 4];
        blank_sel = (BLANK_LZ != 0) && (k != 0) && !nz_above;
      end
    end
    seg_d      = seg_q;
    digit_en_d = digit_en_q;
    if (tick) begin
      seg_d      = blank_sel ? SEG_OFF : bcd_to_seg(sel_digit);
      digit_en_d = ~(DIGITS'(1) << idx_d);
    end
  end

  // State and output registers; everything returns to display-off on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      pre_q      <= '0;
      idx_q      <= '0;
      seg_q      <= SEG_OFF;
      digit_en_q <= '1;
    end else begin
      overflow_q <= overflow_d;
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      digit_en_q <= digit_en_d;
    end
  end

  assign overflow = overflow_q;
  assign seg      = seg_q;
  assign digit_en = digit_en_q;

endmodule

// File: tb/tb_press_count_display.sv
// Bench for press_count_display: an integer-count reference model checked
// every cycle, directed scenarios with literal expectations, and a random phase.
module tb_press_count_display;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int BLANK_LZ = 1;
  localparam int CW       = 4 * DIGITS;
  localparam int MAXC     = 9999;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic pressPulse = 1'b0;
  logic clear = 1'b0;
  logic [CW-1:0]     count_bcd;
  logic              overflow;
  logic [6:0]        seg;
  logic [DIGITS-1:0] digit_en;

  press_count_display #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .BLANK_LZ (BLANK_LZ)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pressPulse (pressPulse),
    .clear      (clear),
    .count_bcd  (count_bcd),
    .overflow   (overflow),
    .seg        (seg),
    .digit_en   (digit_en)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model state: plain integers.
  int m_cnt = 0;
  int m_pre = 0;
  int m_idx = 0;
  bit m_ovf = 1'b0;
  logic [6:0]        m_seg = 7'h7F;
  logic [DIGITS-1:0] m_en  = '1;

  function automatic int p10(input int n);
    int r = 1;
    repeat (n) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [CW-1:0] to_bcd(input int v);
    logic [CW-1:0] r = '0;
    int t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: counter as an integer, display from scan-slot arithmetic.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_cnt = 0; m_pre = 0; m_idx = 0; m_ovf = 1'b0;
      m_seg = 7'h7F; m_en = '1;
    end else begin
      if (m_pre == SCAN_DIV - 1) begin
        m_idx = (m_idx + 1) % DIGITS;
        if (BLANK_LZ != 0 && m_idx > 0 && m_cnt < p10(m_idx)) m_seg = 7'h7F;
        else m_seg = seg_of((m_cnt / p10(m_idx)) % 10);
        m_en = '1;
        m_en[m_idx] = 1'b0;
      end
      m_pre = (m_pre + 1) % SCAN_DIV;
      m_ovf = 1'b0;
      if (clear) m_cnt = 0;
      else if (pressPulse) begin
        if (m_cnt == MAXC) begin m_cnt = 0; m_ovf = 1'b1; end
        else m_cnt = m_cnt + 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("count_bcd", 32'(count_bcd), 32'(to_bcd(m_cnt)));
      check("overflow",  32'(overflow),  32'(m_ovf));
      check("seg",       32'(seg),       32'(m_seg));
      check("digit_en",  32'(digit_en),  32'(m_en));
    end
  end

  task automatic step(input bit p, input bit c);
    pressPulse = p;
    clear      = c;
    @(negedge clock);
    pressPulse = 1'b0;
    clear      = 1'b0;
  endtask

  task automatic wait_en(input logic [DIGITS-1:0] target, input int budget);
    int k = 0;
    while (digit_en !== target && k < budget) begin
      step(1'b0, 1'b0);
      k++;
    end
    check("wait_digit_en", 32'(digit_en), 32'(target));
  endtask

  initial begin
    bit p, c;
    #1 reset = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_count", 32'(count_bcd), 32'h0);
    check("rst_ovf",   32'(overflow),  32'h0);
    check("rst_seg",   32'(seg),       32'h7F);
    check("rst_en",    32'(digit_en),  32'hF);
    reset = 1'b1;

    // Display stays off until the first tick, which selects digit 1 (blank).
    repeat (3) step(1'b0, 1'b0);
    check("pre_tick_en",  32'(digit_en), 32'hF);
    check("pre_tick_seg", 32'(seg),      32'h7F);
    step(1'b0, 1'b0);
    check("first_tick_en",  32'(digit_en), 32'hD);
    check("first_tick_seg", 32'(seg),      32'h7F);

    // Twelve isolated presses.
    repeat (12) begin step(1'b1, 1'b0); step(1'b0, 1'b0); end
    check("twelve_count", 32'(count_bcd), 32'h0012);
    wait_en(4'hE, 2 * DIGITS * SCAN_DIV);
    check("twelve_d0_seg", 32'(seg), 32'h24);
    wait_en(4'hD, 2 * DIGITS * SCAN_DIV);
    check("twelve_d1_seg", 32'(seg), 32'h79);
    wait_en(4'hB, 2 * DIGITS * SCAN_DIV);
    check("twelve_d2_seg", 32'(seg), 32'h7F);
    wait_en(4'h7, 2 * DIGITS * SCAN_DIV);
    check("twelve_d3_seg", 32'(seg), 32'h7F);

    // Wrap from all-9s, then a full 10000 more presses to the next wrap.
    step(1'b0, 1'b1);
    repeat (MAXC) step(1'b1, 1'b0);
    check("preload_count", 32'(count_bcd), 32'h9999);
    check("preload_ovf",   32'(overflow),  32'h0);
    step(1'b1, 1'b0);
    check("wrap_count", 32'(count_bcd), 32'h0);
    check("wrap_ovf",   32'(overflow),  32'h1);
    step(1'b0, 1'b0);
    check("wrap_ovf_drop", 32'(overflow), 32'h0);
    repeat (MAXC) step(1'b1, 1'b0);
    check("rewrap_pre_ovf", 32'(overflow), 32'h0);
    step(1'b1, 1'b0);
    check("rewrap_ovf", 32'(overflow), 32'h1);

    // Clear beats a simultaneous press.
    step(1'b0, 1'b1);
    repeat (57) step(1'b1, 1'b0);
    check("c57_count", 32'(count_bcd), 32'h0057);
    step(1'b1, 1'b1);
    check("clr_press_count", 32'(count_bcd), 32'h0);
    check("clr_press_ovf",   32'(overflow),  32'h0);

    // Held press counts every cycle; first one carries 9 -> 10.
    repeat (9) step(1'b1, 1'b0);
    check("c9_count", 32'(count_bcd), 32'h0009);
    step(1'b1, 1'b0);
    check("carry_count", 32'(count_bcd), 32'h0010);
    repeat (4) step(1'b1, 1'b0);
    check("held_count", 32'(count_bcd), 32'h0014);

    // Asynchronous reset mid-scan with a nonzero count.
    step(1'b0, 1'b1);
    repeat (321) step(1'b1, 1'b0);
    check("c321_count", 32'(count_bcd), 32'h0321);
    wait_en(4'hB, 2 * DIGITS * SCAN_DIV);
    check("c321_d2_seg", 32'(seg), 32'h30);
    #2 reset = 1'b0;
    #1;
    check("async_count", 32'(count_bcd), 32'h0);
    check("async_ovf",   32'(overflow),  32'h0);
    check("async_seg",   32'(seg),       32'h7F);
    check("async_en",    32'(digit_en),  32'hF);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) step(1'b1, 1'b0);
    check("resume_count", 32'(count_bcd), 32'h0003);

    // Random presses and occasional clears.
    repeat (600) begin
      p = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 19) == 0);
      step(p, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
